mux_sel_scanner: RTL and testbench

Upstream control stage for the 4-to-1 mux: it generates the 2-bit select that steps the mux through its channels. It holds each enabled channel for a programmable dwell time, then advances to the next enabled channel in ascending order with wrap-around. Also supports hold and a direct select load. Replaces hand-written select sequencing in benches and top levels.

---
 rtl/mux_sel_scanner.sv | 156 +++++++++++++++
 tb/tb_mux_sel_scanner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_scanner.sv
// Select generator for the 4-to-1 mux: dwells on each enabled channel for a
// programmable number of cycles, then advances to the next enabled channel.
module mux_sel_scanner #(
    parameter int DWELL_W = 10,
    parameter int CH_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               hold,
    input  logic               load,
    input  logic [CH_W-1:0]    load_sel,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [CH_W-1:0]    sel,
    output logic               sel_valid,
    output logic               step,
    output logic               wrap
);

    // state | meaning
    // IDLE  | not scanning, sel_valid low, waiting for en with a non-empty mask
    // SCAN  | dwell counter running on the current channel
    // HOLD  | select and dwell count frozen while hold is high
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NCH = 1 << CH_W;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwl_q, dwl_d;
    logic [CH_W-1:0]    nxt_ch;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [NCH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // Search strictly above cur first; k == NCH lands back on cur itself.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] cur,
                                                input logic [NCH-1:0]  m);
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] idx;
        logic            found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = cur + CH_W'(k);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [DWELL_W-1:0] latch_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    assign nxt_ch = next_ch(sel_q, mask);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        dwl_d   = dwl_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                if (en && (mask != '0)) begin
                    state_d = SCAN;
                    sel_d   = lowest_ch(mask);
                    valid_d = 1'b1;
                    dwl_d   = latch_dwell(dwell);
                end
            end
            SCAN, HOLD: begin
                valid_d = 1'b1;
                if (!en) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (load) begin
                    sel_d = load_sel;
                    cnt_d = '0;
                end else if (hold) begin
                    state_d = HOLD;
                end else begin
                    state_d = SCAN;
                    if (cnt_q == dwl_q - DWELL_W'(1)) begin
                        cnt_d = '0;
                        if (mask == '0) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end else begin
                            sel_d  = nxt_ch;
                            step_d = 1'b1;
                            wrap_d = (nxt_ch <= sel_q);
                            dwl_d  = latch_dwell(dwell);
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            dwl_q   <= DWELL_W'(1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            dwl_q   <= dwl_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = valid_q;
    assign step      = step_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Bench for mux_sel_scanner: per-cycle vector table driven through a
// scoreboard queue, plus a hand-written maximum-dwell sequence.
module tb_mux_sel_scanner;

    localparam int DWELL_W = 10;

    logic               clk = 1'b0;
    logic               rst, en, hold, load;
    logic [1:0]         load_sel;
    logic [3:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         sel;
    logic               sel_valid, step, wrap;

    mux_sel_scanner #(.DWELL_W(DWELL_W), .CH_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .load(load),
        .load_sel(load_sel), .mask(mask), .dwell(dwell),
        .sel(sel), .sel_valid(sel_valid), .step(step), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         r, e, h, l;
        logic [1:0] ls;
        logic [3:0] m;
        int         d;
        logic [4:0] exp;   // {sel, sel_valid, step, wrap}
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic add(input bit r, e, h, l, input int ls, m, d,
                       input int es, input bit ev, est, ew);
        vec_t v;
        v.r = r; v.e = e; v.h = h; v.l = l;
        v.ls = 2'(ls); v.m = 4'(m); v.d = d;
        v.exp = {2'(es), ev, est, ew};
        tbl.push_back(v);
    endtask

    task automatic rst_vec();
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        logic [4:0] want, got;
        int n;

        // full mask, dwell 3
        rst_vec();
        add(0,1,0,0,0,'hF,3, 0,1,0,0);
        add(0,1,0,0,0,'hF,3, 0,1,0,0);
        add(0,1,0,0,0,'hF,3, 0,1,0,0);
        add(0,1,0,0,0,'hF,3, 1,1,1,0);
        add(0,1,0,0,0,'hF,3, 1,1,0,0);
        add(0,1,0,0,0,'hF,3, 1,1,0,0);
        add(0,1,0,0,0,'hF,3, 2,1,1,0);
        add(0,1,0,0,0,'hF,3, 2,1,0,0);
        add(0,1,0,0,0,'hF,3, 2,1,0,0);
        add(0,1,0,0,0,'hF,3, 3,1,1,0);
        add(0,1,0,0,0,'hF,3, 3,1,0,0);
        add(0,1,0,0,0,'hF,3, 3,1,0,0);
        add(0,1,0,0,0,'hF,3, 0,1,1,1);
        // sparse mask 1010, dwell 2
        rst_vec();
        add(0,1,0,0,0,'hA,2, 1,1,0,0);
        add(0,1,0,0,0,'hA,2, 1,1,0,0);
        add(0,1,0,0,0,'hA,2, 3,1,1,0);
        add(0,1,0,0,0,'hA,2, 3,1,0,0);
        add(0,1,0,0,0,'hA,2, 1,1,1,1);
        add(0,1,0,0,0,'hA,2, 1,1,0,0);
        add(0,1,0,0,0,'hA,2, 3,1,1,0);
        // single channel
        rst_vec();
        add(0,1,0,0,0,'h4,2, 2,1,0,0);
        add(0,1,0,0,0,'h4,2, 2,1,0,0);
        add(0,1,0,0,0,'h4,2, 2,1,1,1);
        add(0,1,0,0,0,'h4,2, 2,1,0,0);
        add(0,1,0,0,0,'h4,2, 2,1,1,1);
        // dwell 0 behaves as 1
        rst_vec();
        add(0,1,0,0,0,'hF,0, 0,1,0,0);
        add(0,1,0,0,0,'hF,0, 1,1,1,0);
        add(0,1,0,0,0,'hF,0, 2,1,1,0);
        add(0,1,0,0,0,'hF,0, 3,1,1,0);
        add(0,1,0,0,0,'hF,0, 0,1,1,1);
        add(0,1,0,0,0,'hF,0, 1,1,1,0);
        // dwell change only lands at the next advance
        rst_vec();
        add(0,1,0,0,0,'hF,2, 0,1,0,0);
        add(0,1,0,0,0,'hF,4, 0,1,0,0);
        add(0,1,0,0,0,'hF,4, 1,1,1,0);
        add(0,1,0,0,0,'hF,4, 1,1,0,0);
        add(0,1,0,0,0,'hF,4, 1,1,0,0);
        add(0,1,0,0,0,'hF,4, 1,1,0,0);
        add(0,1,0,0,0,'hF,4, 2,1,1,0);
        // hold, load, load+hold, load during HOLD
        rst_vec();
        add(0,1,0,0,0,'hF,5, 0,1,0,0);
        add(0,1,0,0,0,'hF,5, 0,1,0,0);
        add(0,1,0,0,0,'hF,5, 0,1,0,0);
        for (int i = 0; i < 4; i++) add(0,1,1,0,0,'hF,5, 0,1,0,0);
        add(0,1,0,0,0,'hF,5, 0,1,0,0);
        add(0,1,0,0,0,'hF,5, 0,1,0,0);
        add(0,1,0,0,0,'hF,5, 1,1,1,0);
        add(0,1,0,1,2,'hF,5, 2,1,0,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0,'hF,5, 2,1,0,0);
        add(0,1,0,0,0,'hF,5, 3,1,1,0);
        add(0,1,1,1,1,'hF,5, 1,1,0,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0,'hF,5, 1,1,0,0);
        add(0,1,0,0,0,'hF,5, 2,1,1,0);
        add(0,1,1,0,0,'hF,5, 2,1,0,0);
        add(0,1,1,1,0,'hF,5, 0,1,0,0);
        add(0,1,1,0,0,'hF,5, 0,1,0,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0,'hF,5, 0,1,0,0);
        add(0,1,0,0,0,'hF,5, 1,1,1,0);
        // mask cleared mid-dwell, en drop, en+load, reset mid-dwell
        rst_vec();
        add(0,1,0,0,0,'hF,3, 0,1,0,0);
        add(0,1,0,0,0,'h0,3, 0,1,0,0);
        add(0,1,0,0,0,'h0,3, 0,1,0,0);
        add(0,1,0,0,0,'h0,3, 0,0,0,0);
        add(0,1,0,1,3,'h0,3, 0,0,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);
        add(0,1,0,0,0,'h6,3, 2,1,1,0);
        add(0,0,0,0,0,'h6,3, 2,0,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);
        add(0,0,0,1,3,'h6,3, 1,0,0,0);
        add(0,0,1,0,0,'h6,3, 1,0,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);
        add(1,1,0,0,0,'h6,3, 0,0,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);
        add(0,1,0,0,0,'h6,3, 1,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; en = tbl[i].e; hold = tbl[i].h; load = tbl[i].l;
            load_sel = tbl[i].ls; mask = tbl[i].m; dwell = DWELL_W'(tbl[i].d);
            sb.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            want = sb.pop_front();
            got  = {sel, sel_valid, step, wrap};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL vec[%0d] sel/valid/step/wrap got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                         i, got[4:3], got[2], got[1], got[0],
                         want[4:3], want[2], want[1], want[0]);
            end
        end

        // maximum dwell: first advance lands exactly 1023 cycles after entry
        rst = 1; en = 0; hold = 0; load = 0; load_sel = 0; mask = 4'hF; dwell = '1;
        @(posedge clk); #1;
        rst = 0; en = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (sel_valid !== 1'b1 || sel !== 2'd0) begin
            n_bad++;
            $display("FAIL maxdwell_entry got valid=%0b sel=%0d want valid=1 sel=0", sel_valid, sel);
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!step && n < 1100);
        n_cmp++;
        if (n != 1023) begin
            n_bad++;
            $display("FAIL maxdwell_len got %0d cycles want 1023", n);
        end
        n_cmp++;
        if (sel !== 2'd1 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL maxdwell_adv got sel=%0d wrap=%0b want sel=1 wrap=0", sel, wrap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
